// File: rtl/run_detector_pkg.sv
// Shared constants, per-channel state payload and helpers for run_detector.
package run_detector_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned HIT_W = 8;

    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // Registered state and flag of one detector channel.
    typedef struct packed {
        logic             z;
        logic             val;
        logic [CNT_W-1:0] cnt;
    } chan_out_t;

    // Ceiling log2, used for elaboration-time width checks.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// Sample/result bundle of run_detector. With RUN_DETECTOR_HITCNT_EN defined
// the bundle also carries the per-channel hit counters.
interface run_detector_if
    import run_detector_pkg::*;
#(
    parameter int unsigned CHANNELS = 1
);
    logic                      en;
    logic [CHANNELS-1:0]       w;
    logic [CHANNELS-1:0]       z;
    logic [CHANNELS-1:0]       run_val;
    logic [CHANNELS*CNT_W-1:0] run_cnt;
`ifdef RUN_DETECTOR_HITCNT_EN
    logic [CHANNELS*HIT_W-1:0] hit_cnt;

    modport master (output en, w, input z, run_val, run_cnt, hit_cnt);
    modport slave  (input en, w, output z, run_val, run_cnt, hit_cnt);
`else
    modport master (output en, w, input z, run_val, run_cnt);
    modport slave  (input en, w, output z, run_val, run_cnt);
`endif
endinterface

// File: rtl/run_detector_chan.sv
// One run-detector channel: tracks the current run value and its length,
// raises z when the run reaches RUN_LEN for an enabled polarity.
// Optional macro RUN_DETECTOR_HITCNT_EN adds a saturating hit counter.
module run_detector_chan
    import run_detector_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter logic [1:0]  MODE    = MODE_BOTH,
    parameter int unsigned OVERLAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    output chan_out_t        q
`ifdef RUN_DETECTOR_HITCNT_EN
    ,
    output logic [HIT_W-1:0] hit_cnt
`endif
);

    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
    localparam logic             ONES_EN  = (MODE & MODE_ONES) != 2'b00;
    localparam logic             ZEROS_EN = (MODE & MODE_ZEROS) != 2'b00;

    chan_out_t q_nxt;

    // Next run state; z is decoded from the next state so it leaves a register.
    always_comb begin
        q_nxt = q;
        if (en) begin
            if ((q.cnt == '0) || (w != q.val)) begin
                q_nxt.cnt = CNT_W'(1);
                q_nxt.val = w;
            end else if (q.cnt != RUN_MAX) begin
                q_nxt.cnt = q.cnt + CNT_W'(1);
            end else if (OVERLAP == 0) begin
                q_nxt.cnt = CNT_W'(1);
            end
        end
        q_nxt.z = (q_nxt.cnt == RUN_MAX) && (q_nxt.val ? ONES_EN : ZEROS_EN);
    end

    // Run state register; reset means "no sample seen yet".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

`ifdef RUN_DETECTOR_HITCNT_EN
    logic [HIT_W-1:0] hit_nxt;

    // Count new hits: rising z when runs overlap, every z pulse otherwise.
    always_comb begin
        hit_nxt = hit_cnt;
        if (en && q_nxt.z && ((OVERLAP == 0) || !q.z) && (hit_cnt != '1)) begin
            hit_nxt = hit_cnt + HIT_W'(1);
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt <= '0;
        end else begin
            hit_cnt <= hit_nxt;
        end
    end
`endif

endmodule

// File: rtl/run_detector.sv
// Multi-channel consecutive-value run detector. Each channel is independent;
// outputs are packed per channel onto the slave side of run_detector_if.
// Optional macro RUN_DETECTOR_HITCNT_EN adds per-channel hit counters.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned RUN_LEN  = 4,
    parameter logic [1:0]  MODE     = MODE_BOTH,
    parameter int unsigned OVERLAP  = 1
) (
    input logic           clk,
    input logic           reset,
    run_detector_if.slave bus
);

    if (MODE == 2'b00) begin : g_bad_mode
        $error("run_detector: MODE 2'b00 is illegal");
    end
    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
        $error("run_detector: CHANNELS must be 1..16");
    end
    if ((RUN_LEN < 2) || (RUN_LEN > 15) || (clog2(RUN_LEN + 1) > CNT_W)) begin : g_bad_run_len
        $error("run_detector: RUN_LEN must be 2..15");
    end
    if ($bits(bus.w) != CHANNELS) begin : g_bad_bus
        $error("run_detector: interface CHANNELS does not match");
    end

    chan_out_t q_all [CHANNELS];
`ifdef RUN_DETECTOR_HITCNT_EN
    logic [HIT_W-1:0] hit_all [CHANNELS];
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        run_detector_chan #(
            .RUN_LEN (RUN_LEN),
            .MODE    (MODE),
            .OVERLAP (OVERLAP)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.en),
            .w       (bus.w[i]),
            .q       (q_all[i])
`ifdef RUN_DETECTOR_HITCNT_EN
            ,
            .hit_cnt (hit_all[i])
`endif
        );
    end

    // Pack per-channel registered state onto the bus.
    always_comb begin
        bus.z       = '0;
        bus.run_val = '0;
        bus.run_cnt = '0;
`ifdef RUN_DETECTOR_HITCNT_EN
        bus.hit_cnt = '0;
`endif
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            bus.z[i]                    = q_all[i].z;
            bus.run_val[i]              = q_all[i].val;
            bus.run_cnt[i*CNT_W +: CNT_W] = q_all[i].cnt;
`ifdef RUN_DETECTOR_HITCNT_EN
            bus.hit_cnt[i*HIT_W +: HIT_W] = hit_all[i];
`endif
        end
    end

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised, multi-channel successor to the single-input consecutive-value sequence detector FSM.
- Per channel, asserts a Moore output z once input w has held the same value for RUN_LEN consecutive enabled clock samples.
- Adds channel count, run length, polarity mode, overlap mode and a sample enable.
- Sits between switch/debounce logic and the LED or board top level; one instance replaces several hand-coded one-hot/binary detectors.

Parameters:
- CHANNELS, 1, number of independent detector channels (1..16).
- RUN_LEN, 4, consecutive equal samples required for a hit (2..15).
- MODE, 2'b11, polarity select: 2'b01 detect runs of 1s only; 2'b10 runs of 0s only; 2'b11 both; 2'b00 is illegal (elaboration error).
- OVERLAP, 1, 1 = z stays high while the run continues; 0 = counter restarts after each hit, so z pulses once per RUN_LEN samples.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); release is synchronous to clk.
- en  input  1  sample enable; state updates only when en=1.
- w  input  CHANNELS  per-channel serial input bit.
- z  output  CHANNELS  per-channel detection flag (Moore, registered).
- run_val  output  CHANNELS  value of the current run per channel.
- run_cnt  output  CHANNELS*4  per-channel run length, packed as channel i at [4i+3:4i].

Behaviour:
- Reset (reset=0, asynchronous): run_cnt=0, run_val=0, z=0 on every channel. The reset state represents "no sample yet".
- Per-channel state is (val, cnt), with cnt in 0..RUN_LEN. This is equivalent to the classic states A..(2*RUN_LEN) FSM.
- When en=0, all state and outputs hold.
- When en=1, at each rising edge:
  - cnt==0 -> cnt=1, val=w.
  - w!=val -> cnt=1, val=w.
  - w==val and cnt<RUN_LEN -> cnt=cnt+1.
  - w==val and cnt==RUN_LEN:
    - OVERLAP=1 -> cnt holds at RUN_LEN (saturates).
    - OVERLAP=0 -> cnt=1.
- z = (cnt==RUN_LEN) && polarity enabled for val by MODE.
- z is registered/state-decoded only; no combinational path from w to z.
- Latency: z first rises on the clock edge that captures the RUN_LEN-th equal sample.
- Channels are fully independent; simultaneous hits on several channels are all reported in the same cycle.
- A value change on the cycle after a hit drops z on that edge.
- Reset asserted mid-run clears the run; counting restarts from the first sample after release.
- run_cnt upper bits are zero when RUN_LEN<8.

Optional Feature:
- Macro: RUN_DETECTOR_HITCNT_EN.
- Defined:
  - Adds output port hit_cnt [CHANNELS*8-1:0], an 8-bit saturating counter per channel.
  - Increments on each edge where that channel's z transitions 0->1 (OVERLAP=1), or on each edge where z is 1 (OVERLAP=0).
  - Saturates at 255; reset value 0.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package run_detector_pkg holds:
  - MODE constants MODE_ONES=2'b01, MODE_ZEROS=2'b10, MODE_BOTH=2'b11.
  - CNT_W=4, HIT_W=8.
  - A clog2 function.
- Sub-module run_detector_chan implements one channel's val/cnt/z (and hit_cnt under the macro).
- The top level generates CHANNELS instances of run_detector_chan and packs their outputs.

Test Plan:
- Reset: reset=0 with random w, en=1 -> z=0, run_cnt=0, run_val=0; holds while reset=0.
- Default params, w=1,1,1,1,1,0 with en=1 -> z=0,0,0,1,1,0; run_cnt=1,2,3,4,4,1.
- OVERLAP=0, RUN_LEN=3, w=0 for 7 samples -> z high after samples 3 and 6 only; run_cnt=1,2,3,1,2,3,1.
- MODE=2'b01: w=0 for 5 samples -> z stays 0, run_cnt saturates at 4; then w=1 for 4 samples -> z=1 after the 4th.
- en gating: w=1,1, then en=0 for 3 cycles with w=0, then en=1 with w=1,1 -> z=1 after the 4th enabled sample; run_cnt frozen at 2 during en=0.
- CHANNELS=2: ch0 w=1111, ch1 w=1011 -> z=2'b01 on the 4th edge. Reset pulsed mid-run, then 3 more 1s on ch0 -> z[0]=0.
